chroma_track_filter: RTL and testbench

//  Consumes per-frame chroma-key extents (chr_min_x/chr_max_x) from the chroma-key detector.

---
 rtl/chroma_track_filter_pkg.sv | 20 ++
 rtl/chroma_track_filter_if.sv | 26 ++
 rtl/chroma_avg_filter.sv | 49 ++++
 rtl/chroma_track_filter.sv | 142 ++++++++++++++
 tb/tb_chroma_track_filter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chroma_track_filter_pkg.sv
// Shared types and constants for the chroma-key target tracker.
package chroma_pkg;

  localparam int H_ACTIVE = 640;

  typedef enum logic [1:0] {
    DIR_CENTER = 2'b00,
    DIR_LEFT   = 2'b01,
    DIR_RIGHT  = 2'b10,
    DIR_LOST   = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    FILTER  = 2'b10,
    PUBLISH = 2'b11
  } trk_state_t;

endpackage

// File: rtl/chroma_track_filter_if.sv
// Detector-facing inputs and steering outputs of the tracker.
import chroma_pkg::*;

interface chroma_track_filter_if;
  logic       en;
  logic [9:0] y_pixel;
  logic [9:0] chr_min_x;
  logic [9:0] chr_max_x;
  logic [9:0] avg_center_x;
  logic [9:0] target_width;
  logic       target_valid;
  dir_t       dir;
  logic       upd;

  // Source of video timing / detector extents; consumer of steering
  modport master (
    output en, y_pixel, chr_min_x, chr_max_x,
    input  avg_center_x, target_width, target_valid, dir, upd
  );

  // The tracker itself
  modport slave (
    input  en, y_pixel, chr_min_x, chr_max_x,
    output avg_center_x, target_width, target_valid, dir, upd
  );
endinterface

// File: rtl/chroma_avg_filter.sv
// Moving average of the target centre over 2**AVG_LOG2 frames.
// avg is a look-ahead: it reflects this cycle's preload/push, so the
// caller can register the refreshed average on the same edge.
import chroma_pkg::*;

module chroma_avg_filter #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       preload,
  input  logic       push,
  input  logic [9:0] din,
  output logic [9:0] avg
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 10 + AVG_LOG2;

  logic [DEPTH-1:0][9:0] hist_q, hist_d;
  logic [SW-1:0]         sum_q, sum_d;

  // Preload fills every slot (fresh acquisition); push shifts one centre in
  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) hist_d[i] = din;
      sum_d = SW'(din) << AVG_LOG2;
    end else if (push) begin
      hist_d[0] = din;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      sum_d = sum_q + SW'(din) - SW'(hist_q[DEPTH-1]);
    end
  end

  // History and running sum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      sum_q  <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
    end
  end

  assign avg = sum_d[AVG_LOG2 +: 10];

endmodule

// File: rtl/chroma_track_filter.sv
// Per-frame chroma target tracker: samples detector extents as the scan
// leaves SAMPLE_LINE, validates, averages the centre, tracks loss and
// publishes a registered steering direction once per frame.
import chroma_pkg::*;

module chroma_track_filter #(
  parameter int SAMPLE_LINE = 240,
  parameter int CENTER_X    = 320,
  parameter int DEADBAND    = 16,
  parameter int MIN_WIDTH   = 8,
  parameter int AVG_LOG2    = 2,
  parameter int LOST_FRAMES = 8
) (
  input  logic                  vga_pclk,
  input  logic                  reset_n,
  chroma_track_filter_if.slave  bus
);
  localparam int LW = $clog2(LOST_FRAMES + 1);

  trk_state_t    state_q, state_d;
  logic [9:0]    y_prev_q, y_prev_d;
  logic [9:0]    min_q, min_d, max_q, max_d;
  logic [LW-1:0] lost_q, lost_d;
  logic          acq_q, acq_d;
  logic [9:0]    avg_q, avg_d, width_q, width_d;
  logic          valid_q, valid_d, upd_q, upd_d;
  dir_t          dir_q, dir_d;

  logic          sample_evt, smp_valid, preload, push;
  logic [10:0]   smp_width, smp_sum;
  logic [9:0]    smp_center, filt_avg;

  function automatic dir_t steer(input logic [9:0] a);
    if (int'(a) < CENTER_X - DEADBAND)      return DIR_LEFT;
    else if (int'(a) > CENTER_X + DEADBAND) return DIR_RIGHT;
    else                                    return DIR_CENTER;
  endfunction

  assign sample_evt = bus.en && (y_prev_q == 10'(SAMPLE_LINE)) &&
                      (bus.y_pixel != 10'(SAMPLE_LINE));

  // Sample qualification on the latched extents (11-bit so no wrap)
  assign smp_width  = {1'b0, max_q} - {1'b0, min_q};
  assign smp_valid  = (max_q > min_q) && (smp_width >= 11'(MIN_WIDTH));
  assign smp_sum    = {1'b0, min_q} + {1'b0, max_q};
  assign smp_center = smp_sum[10:1];

  assign preload = (state_q == FILTER) && smp_valid && !acq_q;
  assign push    = (state_q == FILTER) && smp_valid &&  acq_q;

  chroma_avg_filter #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk     (vga_pclk),
    .rst_n   (reset_n),
    .preload (preload),
    .push    (push),
    .din     (smp_center),
    .avg     (filt_avg)
  );

  // Next-state: sequencer, loss tracking and output staging.
  // Outputs are loaded on the FILTER->PUBLISH edge so that they and upd
  // are live for the whole PUBLISH cycle.
  always_comb begin
    state_d  = state_q;
    y_prev_d = bus.y_pixel;
    min_d    = min_q;
    max_d    = max_q;
    lost_d   = lost_q;
    acq_d    = acq_q;
    avg_d    = avg_q;
    width_d  = width_q;
    valid_d  = valid_q;
    dir_d    = dir_q;
    upd_d    = 1'b0;
    unique case (state_q)
      IDLE:    if (sample_evt) state_d = CAPTURE;
      CAPTURE: begin
        min_d   = bus.chr_min_x;
        max_d   = bus.chr_max_x;
        state_d = FILTER;
      end
      FILTER: begin
        state_d = PUBLISH;
        upd_d   = 1'b1;
        if (smp_valid) begin
          lost_d = '0;
          acq_d  = 1'b1;
        end else begin
          if (lost_q < LW'(LOST_FRAMES)) lost_d = lost_q + 1'b1;
          if (lost_d == LW'(LOST_FRAMES)) acq_d = 1'b0;
        end
        if (acq_d) begin
          avg_d   = filt_avg;
          valid_d = 1'b1;
          dir_d   = steer(filt_avg);
          if (smp_valid) width_d = smp_width[9:0];
        end else begin
          valid_d = 1'b0;
          dir_d   = DIR_LOST;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All tracker state and registered outputs
  always_ff @(posedge vga_pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      y_prev_q <= '0;
      min_q    <= '0;
      max_q    <= '0;
      lost_q   <= '0;
      acq_q    <= 1'b0;
      avg_q    <= 10'(CENTER_X);
      width_q  <= '0;
      valid_q  <= 1'b0;
      dir_q    <= DIR_LOST;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_prev_q <= y_prev_d;
      min_q    <= min_d;
      max_q    <= max_d;
      lost_q   <= lost_d;
      acq_q    <= acq_d;
      avg_q    <= avg_d;
      width_q  <= width_d;
      valid_q  <= valid_d;
      dir_q    <= dir_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.avg_center_x = avg_q;
  assign bus.target_width = width_q;
  assign bus.target_valid = valid_q;
  assign bus.dir          = dir_q;
  assign bus.upd          = upd_q;

endmodule

// File: tb/tb_chroma_track_filter.sv
// Randomized + directed bench for chroma_track_filter against a
// frame-level reference model (history queue, plain averaging).
import chroma_pkg::*;

module tb_chroma_track_filter;
  localparam int SAMPLE = 240;
  localparam int CX     = 320;
  localparam int DB     = 16;
  localparam int MINW   = 8;
  localparam int LOSTN  = 8;
  localparam int DEPTH  = 4;

  logic vga_pclk = 1'b0;
  logic reset_n  = 1'b0;

  chroma_track_filter_if bus();

  chroma_track_filter dut (
    .vga_pclk (vga_pclk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 vga_pclk = ~vga_pclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expected outputs currently on the pins
  int e_avg, e_width, e_valid, e_dir, e_upd;
  // Expected outputs scheduled for a future publish cycle
  int p_cyc = -1;
  int p_avg, p_width, p_valid, p_dir;
  // Frame-level model state
  int  hist[$];
  bit  m_acq;
  int  m_lost, m_avg, m_width, m_valid, m_dir;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dir_of(input int a);
    if (a < CX - DB) return 1;
    if (a > CX + DB) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    hist    = {};
    m_acq   = 0;
    m_lost  = 0;
    m_avg   = CX;
    m_width = 0;
    m_valid = 0;
    m_dir   = 3;
    e_avg = m_avg; e_width = m_width; e_valid = m_valid; e_dir = m_dir; e_upd = 0;
    p_cyc = -1;
  endtask

  // One accepted sample: update the model and schedule the publish.
  task automatic model_event(input int mn, input int mx);
    int c, s;
    c = (mn + mx) / 2;
    if (mx > mn && (mx - mn) >= MINW) begin
      m_lost = 0;
      if (!m_acq) begin
        hist = {};
        repeat (DEPTH) hist.push_front(c);
        m_acq = 1;
      end else begin
        hist.push_front(c);
        void'(hist.pop_back());
      end
      m_width = mx - mn;
    end else begin
      if (m_lost < LOSTN) m_lost++;
      if (m_lost == LOSTN) m_acq = 0;
    end
    if (m_acq) begin
      s = 0;
      foreach (hist[i]) s += hist[i];
      m_avg   = s / DEPTH;
      m_valid = 1;
      m_dir   = dir_of(m_avg);
    end else begin
      m_valid = 0;
      m_dir   = 3;
    end
    p_avg = m_avg; p_width = m_width; p_valid = m_valid; p_dir = m_dir;
    // event seen at negedge cyc+1; publish visible 3 cycles later
    p_cyc = cyc + 4;
  endtask

  // Every-cycle compare against the model
  always @(negedge vga_pclk) begin
    cyc++;
    if (p_cyc == cyc) begin
      e_avg = p_avg; e_width = p_width; e_valid = p_valid; e_dir = p_dir;
      e_upd = 1;
      p_cyc = -1;
    end else begin
      e_upd = 0;
    end
    check("upd",          int'(bus.upd),          e_upd);
    check("avg_center_x", int'(bus.avg_center_x), e_avg);
    check("target_width", int'(bus.target_width), e_width);
    check("target_valid", int'(bus.target_valid), e_valid);
    check("dir",          int'(bus.dir),          e_dir);
  end

  // Drive one frame's worth of lines around the sample line.
  task automatic do_frame(input int mn, input int mx, input bit en_v, input bit drop);
    @(posedge vga_pclk); #1;
    bus.chr_min_x = 10'(mn);
    bus.chr_max_x = 10'(mx);
    bus.en        = en_v;
    bus.y_pixel   = 10'(SAMPLE - 2);
    @(posedge vga_pclk); #1 bus.y_pixel = 10'(SAMPLE);
    @(posedge vga_pclk); #1 bus.y_pixel = 10'(SAMPLE);
    @(posedge vga_pclk); #1 bus.y_pixel = 10'(SAMPLE + 1);
    if (en_v) model_event(mn, mx);
    if (drop) begin
      @(posedge vga_pclk); #1 bus.en = 1'b0;
    end
    repeat (7) @(posedge vga_pclk);
    #1;
    bus.en      = 1'b1;
    bus.y_pixel = '0;
  endtask

  task automatic check_out(input string nm, input int a, input int w, input int v, input int d);
    check({nm, ".avg"},   int'(bus.avg_center_x), a);
    check({nm, ".width"}, int'(bus.target_width), w);
    check({nm, ".valid"}, int'(bus.target_valid), v);
    check({nm, ".dir"},   int'(bus.dir),          d);
  endtask

  initial begin
    int t2_exp[4];
    int t4_ramp[4];
    int mn, mx, r;
    t2_exp  = '{270, 220, 170, 120};
    t4_ramp = '{190, 260, 330, 400};

    bus.en = 1'b1; bus.y_pixel = '0; bus.chr_min_x = '0; bus.chr_max_x = '0;
    model_reset();
    repeat (3) @(posedge vga_pclk);
    check_out("reset", CX, 0, 0, 3);
    check("reset.upd", int'(bus.upd), 0);
    #1 reset_n = 1'b1;

    // Narrow sample with nothing acquired: LOST, upd still pulses
    do_frame(500, 504, 1, 0);
    check_out("narrow_unacq", 320, 0, 0, 3);

    // First valid frame preloads the history
    do_frame(300, 340, 1, 0);
    check_out("acquire", 320, 40, 1, 0);

    // Moving left: each frame pushes centre 120
    for (int i = 0; i < 4; i++) begin
      do_frame(100, 140, 1, 0);
      check_out($sformatf("left%0d", i), t2_exp[i], 40, 1, 1);
    end

    // Ramp to 400, then eight lost frames
    for (int i = 0; i < 4; i++) begin
      do_frame(380, 420, 1, 0);
      check($sformatf("ramp%0d", i), int'(bus.avg_center_x), t4_ramp[i]);
    end
    check_out("track400", 400, 40, 1, 2);
    for (int i = 1; i <= LOSTN; i++) begin
      do_frame(200, 100, 1, 0);
      if (i < LOSTN) check_out($sformatf("hold%0d", i), 400, 40, 1, 2);
      else           check_out("lost", 400, 40, 0, 3);
    end

    // Re-acquire at the right edge: history preloaded
    do_frame(600, 639, 1, 0);
    check_out("reacq", 619, 39, 1, 2);

    // Boundary widths and full-screen extents
    do_frame(0, 639, 1, 0);
    check_out("fullscreen", 544, 639, 1, 2);
    do_frame(200, 207, 1, 0);
    check_out("width7", 544, 639, 1, 2);
    do_frame(200, 208, 1, 0);
    check("width8", int'(bus.target_width), 8);

    // en low across the sample line: no sample, nothing changes
    do_frame(100, 200, 0, 0);
    check("en_low.width", int'(bus.target_width), 8);
    // en dropped after the event: sequence still completes
    do_frame(300, 340, 1, 1);

    // Reset during FILTER
    @(posedge vga_pclk); #1;
    bus.chr_min_x = 10'd300; bus.chr_max_x = 10'd340; bus.y_pixel = 10'(SAMPLE - 2);
    @(posedge vga_pclk); #1 bus.y_pixel = 10'(SAMPLE);
    @(posedge vga_pclk); #1 bus.y_pixel = 10'(SAMPLE + 1);
    @(posedge vga_pclk);
    @(posedge vga_pclk); #1;
    reset_n = 1'b0;
    model_reset();
    @(posedge vga_pclk); #1 reset_n = 1'b1;
    repeat (6) @(posedge vga_pclk);
    check_out("midreset", CX, 0, 0, 3);
    bus.y_pixel = '0;
    do_frame(380, 420, 1, 0);
    check_out("post_reset", 400, 40, 1, 2);

    // Randomized frames, with occasional long invalid bursts
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25 || (i % 20) >= 10 && (i % 20) < 19) begin
        mn = int'($urandom_range(0, H_ACTIVE - 1));
        if ($urandom_range(0, 1) == 0) mx = int'($urandom_range(0, mn));
        else begin
          mx = mn + int'($urandom_range(0, MINW - 1));
          if (mx > H_ACTIVE - 1) mx = H_ACTIVE - 1;
        end
      end else begin
        mn = int'($urandom_range(0, H_ACTIVE - 1 - MINW));
        mx = mn + int'($urandom_range(MINW, H_ACTIVE - 1 - mn));
      end
      do_frame(mn, mx, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
    end

    repeat (4) @(posedge vga_pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
